// File: rtl/toplayici_hakem.sv
// toplayici_hakem
// Round-robin arbiter and sequencer in front of one shared combinational
// 32-bit adder. A granted request is run as one pass (32-bit op) or two
// passes (64-bit op, low word first, carry chained into the high word),
// then the result is held until the consumer takes it.
//
// Optional feature macro: TOPLAYICI_HAKEM_TASMA_EN adds sonuc_tasma_o,
// the signed overflow of the final word.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   istek_gecerli_i      per-requester request valid
//   istek_hazir_o        per-requester accept, one-hot or zero, BOSTA only
//   istek_islec0/1_i     64-bit operands A/B per requester, packed by index
//   istek_cikar_i        1 = A-B, 0 = A+B
//   istek_genis_i        1 = 64-bit op, 0 = 32-bit op on the low words
//   sonuc_gecerli_o/sonuc_hazir_i  result handshake
//   sonuc_o, sonuc_carry_o, sonuc_kimlik_o  result, final carry, owner id
//   sonuc_tasma_o        signed overflow (macro builds only)
//   top_islec0/1_o, top_carry_o    drive to the shared adder
//   top_toplam_i, top_carry_i      sum and carry back from the adder
module toplayici_hakem #(
   parameter int NUM_REQ  = 4,
   parameter int KIMLIK_W = $clog2(NUM_REQ)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [NUM_REQ-1:0]    istek_gecerli_i,
   output logic [NUM_REQ-1:0]    istek_hazir_o,
   input  logic [NUM_REQ*64-1:0] istek_islec0_i,
   input  logic [NUM_REQ*64-1:0] istek_islec1_i,
   input  logic [NUM_REQ-1:0]    istek_cikar_i,
   input  logic [NUM_REQ-1:0]    istek_genis_i,
   output logic                  sonuc_gecerli_o,
   input  logic                  sonuc_hazir_i,
   output logic [63:0]           sonuc_o,
   output logic                  sonuc_carry_o,
   output logic [KIMLIK_W-1:0]   sonuc_kimlik_o,
`ifdef TOPLAYICI_HAKEM_TASMA_EN
   output logic                  sonuc_tasma_o,
`endif
   output logic [31:0]           top_islec0_o,
   output logic [31:0]           top_islec1_o,
   output logic                  top_carry_o,
   input  logic [31:0]           top_toplam_i,
   input  logic                  top_carry_i
);

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ALT   = 2'd1,
      UST   = 2'd2,
      YANIT = 2'd3
   } durum_t;

   durum_t              durum_r;
   durum_t              durum_s;
   logic [KIMLIK_W-1:0] ptr_r;
   logic [KIMLIK_W-1:0] kimlik_r;
   logic [63:0]         a_r;
   logic [63:0]         b_r;
   logic                cikar_r;
   logic                genis_r;
   logic [63:0]         sonuc_r;
   logic                carry_r;
   logic [63:0]         b_ters_s;
   logic                bulundu_s;
   logic [KIMLIK_W-1:0] secim_s;

   // Subtraction is A + ~B + 1, so B is inverted and the carry-in seeded with 1.
   function automatic logic [63:0] islec_b_hazirla(input logic [63:0] b, input logic cikar);
      return cikar ? ~b : b;
   endfunction

`ifdef TOPLAYICI_HAKEM_TASMA_EN
   logic tasma_r;

   // Signed overflow: operands agree in sign but the sum does not.
   function automatic logic tasma_hesapla(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) & (r_msb != a_msb);
   endfunction

   assign sonuc_tasma_o = tasma_r;
`endif

   assign b_ters_s       = islec_b_hazirla(b_r, cikar_r);
   assign sonuc_o        = sonuc_r;
   assign sonuc_carry_o  = carry_r;
   assign sonuc_kimlik_o = kimlik_r;

   // Round-robin search: first valid requester strictly after the pointer.
   always_comb begin
      bulundu_s = 1'b0;
      secim_s   = {KIMLIK_W{1'b0}};
      for (int i = 1; i <= NUM_REQ; i++) begin
         int  aday;
         logic isabet;
         aday      = (int'(ptr_r) + i) % NUM_REQ;
         isabet    = istek_gecerli_i[aday] & ~bulundu_s;
         secim_s   = isabet ? KIMLIK_W'(aday) : secim_s;
         bulundu_s = bulundu_s | isabet;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum_r <= BOSTA;
      end else begin
         durum_r <= durum_s;
      end
   end

   // Next-state, accept pulse and adder drive.
   always_comb begin
      durum_s         = durum_r;
      istek_hazir_o   = {NUM_REQ{1'b0}};
      sonuc_gecerli_o = 1'b0;
      top_islec0_o    = 32'd0;
      top_islec1_o    = 32'd0;
      top_carry_o     = 1'b0;
      case (durum_r)
         BOSTA: begin
            if (bulundu_s) begin
               // Gated by reset so the accept stays low while reset is held.
               istek_hazir_o[secim_s] = rstn_i;
               durum_s                = ALT;
            end else begin
               durum_s = BOSTA;
            end
         end
         ALT: begin
            top_islec0_o = a_r[31:0];
            top_islec1_o = b_ters_s[31:0];
            top_carry_o  = cikar_r;
            durum_s      = genis_r ? UST : YANIT;
         end
         UST: begin
            top_islec0_o = a_r[63:32];
            top_islec1_o = b_ters_s[63:32];
            top_carry_o  = carry_r;
            durum_s      = YANIT;
         end
         YANIT: begin
            sonuc_gecerli_o = 1'b1;
            if (sonuc_hazir_i) begin
               durum_s = BOSTA;
            end else begin
               durum_s = YANIT;
            end
         end
         default: begin
            durum_s = BOSTA;
         end
      endcase
   end

   // Operand capture at grant, result and carry capture per adder pass.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ptr_r    <= KIMLIK_W'(NUM_REQ - 1);
         kimlik_r <= {KIMLIK_W{1'b0}};
         a_r      <= 64'd0;
         b_r      <= 64'd0;
         cikar_r  <= 1'b0;
         genis_r  <= 1'b0;
         sonuc_r  <= 64'd0;
         carry_r  <= 1'b0;
`ifdef TOPLAYICI_HAKEM_TASMA_EN
         tasma_r  <= 1'b0;
`endif
      end else begin
         case (durum_r)
            BOSTA: begin
               if (bulundu_s) begin
                  a_r      <= istek_islec0_i[64*secim_s +: 64];
                  b_r      <= istek_islec1_i[64*secim_s +: 64];
                  cikar_r  <= istek_cikar_i[secim_s];
                  genis_r  <= istek_genis_i[secim_s];
                  kimlik_r <= secim_s;
                  ptr_r    <= secim_s;
               end
            end
            ALT: begin
               // Clearing the high word here makes 32-bit results zero-extended.
               sonuc_r <= {32'd0, top_toplam_i};
               carry_r <= top_carry_i;
`ifdef TOPLAYICI_HAKEM_TASMA_EN
               tasma_r <= tasma_hesapla(a_r[31], b_ters_s[31], top_toplam_i[31]);
`endif
            end
            UST: begin
               sonuc_r[63:32] <= top_toplam_i;
               carry_r        <= top_carry_i;
`ifdef TOPLAYICI_HAKEM_TASMA_EN
               tasma_r        <= tasma_hesapla(a_r[63], b_ters_s[63], top_toplam_i[31]);
`endif
            end
            YANIT: begin
               sonuc_r <= sonuc_r;
            end
            default: begin
               sonuc_r <= sonuc_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toplayici_hakem.sv
// Testbench for toplayici_hakem: a combinational adder model closes the
// loop, a monitor pushes the expected result at every accept and compares
// it when the result is presented.
module tb_toplayici_hakem;

   localparam int N = 4;

   logic            clk_i = 1'b0;
   logic            rstn_i;
   logic [N-1:0]    istek_gecerli_i;
   logic [N-1:0]    istek_hazir_o;
   logic [N*64-1:0] istek_islec0_i;
   logic [N*64-1:0] istek_islec1_i;
   logic [N-1:0]    istek_cikar_i;
   logic [N-1:0]    istek_genis_i;
   logic            sonuc_gecerli_o;
   logic            sonuc_hazir_i;
   logic [63:0]     sonuc_o;
   logic            sonuc_carry_o;
   logic [1:0]      sonuc_kimlik_o;
   logic [31:0]     top_islec0_o;
   logic [31:0]     top_islec1_o;
   logic            top_carry_o;
   logic [31:0]     top_toplam_i;
   logic            top_carry_i;
`ifdef TOPLAYICI_HAKEM_TASMA_EN
   logic            sonuc_tasma_o;
`endif

   toplayici_hakem #(.NUM_REQ(N)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
      .istek_islec0_i(istek_islec0_i), .istek_islec1_i(istek_islec1_i),
      .istek_cikar_i(istek_cikar_i), .istek_genis_i(istek_genis_i),
      .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i),
      .sonuc_o(sonuc_o), .sonuc_carry_o(sonuc_carry_o), .sonuc_kimlik_o(sonuc_kimlik_o),
`ifdef TOPLAYICI_HAKEM_TASMA_EN
      .sonuc_tasma_o(sonuc_tasma_o),
`endif
      .top_islec0_o(top_islec0_o), .top_islec1_o(top_islec1_o), .top_carry_o(top_carry_o),
      .top_toplam_i(top_toplam_i), .top_carry_i(top_carry_i)
   );

   // Shared adder
   assign {top_carry_i, top_toplam_i} = {1'b0, top_islec0_o} + {1'b0, top_islec1_o} + {32'd0, top_carry_o};

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] sonuc;
      logic        carry;
      int          kimlik;
      int          gecikme;
      logic        tasma;
      int          kabul;
   } beklenen_t;

   beklenen_t beklenen_q[$];
   int        grant_q[$];
   int        toplam = 0;
   int        hatali = 0;
   int        cyc = 0;
   int        son_kabul_cyc = 0;
   int        son_el_cyc = 0;
   bit        onceki = 1'b0;

   task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
      toplam++;
      if (gozlenen !== beklenen) begin
         hatali++;
         $display("FAIL %s: gozlenen=%0h beklenen=%0h (t=%0t)", etiket, gozlenen, beklenen, $time);
      end
   endtask

   function automatic beklenen_t model(input logic [63:0] a, input logic [63:0] b,
                                       input logic cikar, input logic genis, input int k, input int c);
      beklenen_t   e;
      logic [63:0] aa, bb, r;
      logic [64:0] s;
      int          m;
      aa = genis ? a : {32'd0, a[31:0]};
      bb = genis ? b : {32'd0, b[31:0]};
      if (cikar) begin
         r       = aa - bb;
         e.carry = (aa >= bb);
      end else begin
         s       = {1'b0, aa} + {1'b0, bb};
         r       = s[63:0];
         e.carry = genis ? s[64] : s[32];
      end
      if (!genis) r[63:32] = 32'd0;
      m = genis ? 63 : 31;
      if (cikar) e.tasma = (aa[m] != bb[m]) && (r[m] != aa[m]);
      else       e.tasma = (aa[m] == bb[m]) && (r[m] != aa[m]);
      e.sonuc   = r;
      e.kimlik  = k;
      e.gecikme = genis ? 3 : 2;
      e.kabul   = c;
      return e;
   endfunction

   always @(posedge clk_i) cyc++;

   // Monitor: accept-side scoreboard push and result-side compare.
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         onceki = 1'b0;
      end else begin
         if (istek_hazir_o != 4'd0) begin
            int k;
            k = 0;
            kontrol("hazir_onehot", 64'($onehot(istek_hazir_o)), 64'd1);
            kontrol("hazir_gecersiz", 64'(istek_hazir_o & ~istek_gecerli_i), 64'd0);
            for (int i = 0; i < N; i++) if (istek_hazir_o[i]) k = i;
            beklenen_q.push_back(model(istek_islec0_i[64*k +: 64], istek_islec1_i[64*k +: 64],
                                       istek_cikar_i[k], istek_genis_i[k], k, cyc));
            grant_q.push_back(k);
            son_kabul_cyc = cyc;
         end
         if (sonuc_gecerli_o) begin
            kontrol("yanit_hazir_darbe", 64'(istek_hazir_o), 64'd0);
            if (beklenen_q.size() == 0) begin
               kontrol("beklenmeyen_sonuc", 64'd1, 64'd0);
            end else begin
               beklenen_t e;
               e = beklenen_q[0];
               if (!onceki) kontrol("gecikme", 64'(cyc - e.kabul), 64'(e.gecikme));
               kontrol("sonuc", sonuc_o, e.sonuc);
               kontrol("carry", 64'(sonuc_carry_o), 64'(e.carry));
               kontrol("kimlik", 64'(sonuc_kimlik_o), 64'(e.kimlik));
`ifdef TOPLAYICI_HAKEM_TASMA_EN
               kontrol("tasma", 64'(sonuc_tasma_o), 64'(e.tasma));
`endif
               if (sonuc_hazir_i) begin
                  void'(beklenen_q.pop_front());
                  son_el_cyc = cyc;
               end
            end
         end
         onceki = sonuc_gecerli_o && !sonuc_hazir_i;
      end
   end

   task automatic islec_yaz(input int k, input logic [63:0] a, input logic [63:0] b,
                            input logic cikar, input logic genis);
      istek_islec0_i[64*k +: 64] = a;
      istek_islec1_i[64*k +: 64] = b;
      istek_cikar_i[k] = cikar;
      istek_genis_i[k] = genis;
   endtask

   // Raise one request, wait for its accept, drop valid; returns in the ALT cycle.
   task automatic istek_yap(input int k, input logic [63:0] a, input logic [63:0] b,
                            input logic cikar, input logic genis);
      bit goruldu;
      goruldu = 1'b0;
      islec_yaz(k, a, b, cikar, genis);
      istek_gecerli_i[k] = 1'b1;
      for (int i = 0; i < 50 && !goruldu; i++) begin
         @(negedge clk_i);
         if (istek_hazir_o[k]) goruldu = 1'b1;
      end
      if (!goruldu) kontrol("kabul_zaman_asimi", 64'd1, 64'd0);
      @(posedge clk_i); #1;
      istek_gecerli_i[k] = 1'b0;
   endtask

   task automatic bosalt();
      for (int i = 0; i < 50 && beklenen_q.size() != 0; i++) begin
         @(posedge clk_i); #1;
      end
      if (beklenen_q.size() != 0) kontrol("sonuc_zaman_asimi", 64'd1, 64'd0);
      @(posedge clk_i); #1;
   endtask

   task automatic sifirla();
      rstn_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      beklenen_q.delete();
      grant_q.delete();
      rstn_i = 1'b1;
   endtask

   initial begin
      int n0;
      rstn_i = 1'b0;
      istek_gecerli_i = 4'hF;
      istek_islec0_i = '0; istek_islec1_i = '0;
      istek_cikar_i = 4'd0; istek_genis_i = 4'd0;
      sonuc_hazir_i = 1'b1;
      #2;
      kontrol("reset_hazir", 64'(istek_hazir_o), 64'd0);
      kontrol("reset_gecerli", 64'(sonuc_gecerli_o), 64'd0);
      kontrol("reset_sonuc", sonuc_o, 64'd0);
      kontrol("reset_top", {top_islec0_o, top_islec1_o} | 64'(top_carry_o), 64'd0);
      istek_gecerli_i = 4'd0;
      sifirla();

      // 1: 32-bit add with carry out
      istek_yap(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      bosalt();

      // 2: 64-bit add, carry chained into the high pass
      istek_yap(1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
      @(negedge clk_i);
      kontrol("alt_carry_in", 64'(top_carry_o), 64'd0);
      kontrol("alt_islec0", 64'(top_islec0_o), 64'hFFFF_FFFF);
      @(negedge clk_i);
      kontrol("ust_carry_in", 64'(top_carry_o), 64'd1);
      kontrol("ust_islec0", 64'(top_islec0_o), 64'd0);
      @(posedge clk_i); #1;
      bosalt();

      // 3: subtracts
      istek_yap(2, 64'd5, 64'd7, 1'b1, 1'b0);
      bosalt();
      istek_yap(2, 64'd7, 64'd5, 1'b1, 1'b0);
      bosalt();
      istek_yap(2, 64'd0, 64'd1, 1'b1, 1'b1);
      bosalt();
      istek_yap(3, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
      bosalt();

      // 4: all requesters valid continuously
      sifirla();
      islec_yaz(0, 64'h11, 64'h22, 1'b0, 1'b0);
      islec_yaz(1, 64'h1_0000_0005, 64'h3, 1'b1, 1'b0);
      islec_yaz(2, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_FFFF_FFFF, 1'b0, 1'b1);
      islec_yaz(3, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0);
      istek_gecerli_i = 4'hF;
      for (int i = 0; i < 100 && grant_q.size() < 5; i++) begin
         @(posedge clk_i); #1;
      end
      istek_gecerli_i = 4'd0;
      kontrol("grant_sayisi", 64'(grant_q.size()), 64'd5);
      for (int i = 0; i < 5 && i < grant_q.size(); i++)
         kontrol($sformatf("grant_sira%0d", i), 64'(grant_q[i]), 64'(i % 4));
      bosalt();

      // 5: consumer stalls in YANIT with a competing request pending
      sonuc_hazir_i = 1'b0;
      istek_yap(1, 64'hCAFE_0000_1234_0000, 64'h0000_0001_0000_0001, 1'b0, 1'b1);
      islec_yaz(3, 64'd100, 64'd1, 1'b0, 1'b0);
      istek_gecerli_i[3] = 1'b1;
      n0 = grant_q.size();
      repeat (7) begin
         @(posedge clk_i); #1;
      end
      kontrol("duraklama_kabul_yok", 64'(grant_q.size()), 64'(n0));
      sonuc_hazir_i = 1'b1;
      for (int i = 0; i < 20 && grant_q.size() == n0; i++) begin
         @(posedge clk_i); #1;
      end
      istek_gecerli_i[3] = 1'b0;
      kontrol("el_sikisma_sonrasi_kabul", 64'(son_kabul_cyc - son_el_cyc), 64'd1);
      if (grant_q.size() > n0) kontrol("duraklama_grant", 64'(grant_q[$]), 64'd3);
      else kontrol("duraklama_grant_yok", 64'd1, 64'd0);
      bosalt();

      // 6: reset during the high pass drops the op
      istek_yap(2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b1);
      @(posedge clk_i); #1;
      istek_gecerli_i = 4'b0010;
      #2 rstn_i = 1'b0;
      #1;
      kontrol("rst_hazir", 64'(istek_hazir_o), 64'd0);
      kontrol("rst_gecerli", 64'(sonuc_gecerli_o), 64'd0);
      kontrol("rst_sonuc", sonuc_o, 64'd0);
      kontrol("rst_carry_kimlik", {62'd0, sonuc_carry_o, 1'b0} | 64'(sonuc_kimlik_o), 64'd0);
      kontrol("rst_top", {top_islec0_o, top_islec1_o} | 64'(top_carry_o), 64'd0);
      beklenen_q.delete();
      istek_gecerli_i = 4'b0101;
      islec_yaz(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
      islec_yaz(2, 64'd9, 64'd9, 1'b1, 1'b0);
      @(posedge clk_i); @(posedge clk_i); #1;
      n0 = grant_q.size();
      rstn_i = 1'b1;
      for (int i = 0; i < 20 && grant_q.size() == n0; i++) begin
         @(posedge clk_i); #1;
      end
      istek_gecerli_i = 4'd0;
      if (grant_q.size() > n0) kontrol("reset_sonrasi_grant", 64'(grant_q[$]), 64'd0);
      else kontrol("reset_sonrasi_grant_yok", 64'd1, 64'd0);
      bosalt();

      // Signed overflow on a 32-bit add and a 64-bit subtract
      istek_yap(1, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
      bosalt();
      istek_yap(3, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
      bosalt();

      kontrol("kuyruk_bos", 64'(beklenen_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", toplam, hatali);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: gozlenen=timeout beklenen=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/toplayici_hakem.md
Name: toplayici_hakem

Overview:
Arbiter and sequencer that shares one combinational 32-bit prefix adder among NUM_REQ requesters. Supports 32-bit and 64-bit add/subtract. 64-bit operations run as two passes, chaining the adder carry-out into the next carry-in. Sits between execution-unit requesters and the shared adder; drives the adder operand and carry ports directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
KIMLIK_W, $clog2(NUM_REQ), width of the requester id.

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
istek_gecerli_i  input  NUM_REQ  per-requester request valid
istek_hazir_o  output  NUM_REQ  per-requester accept (one-hot or zero)
istek_islec0_i  input  NUM_REQ*64  operand A; requester k occupies bits [64k+63:64k]
istek_islec1_i  input  NUM_REQ*64  operand B, same packing
istek_cikar_i  input  NUM_REQ  1 = A-B, 0 = A+B
istek_genis_i  input  NUM_REQ  1 = 64-bit op, 0 = 32-bit op (low words only)
sonuc_gecerli_o  output  1  result valid
sonuc_hazir_i  input  1  result consumer ready
sonuc_o  output  64  result
sonuc_carry_o  output  1  final carry out (for subtract: 1 = no borrow)
sonuc_kimlik_o  output  KIMLIK_W  id of the requester that owns the result
top_islec0_o  output  32  to adder islec0
top_islec1_o  output  32  to adder islec1
top_carry_o  output  1  to adder carry in
top_toplam_i  input  32  from adder sum
top_carry_i  input  1  from adder carry out

Behaviour:
- One clock domain. rstn_i low forces asynchronously: state BOSTA, all outputs 0, RR pointer = NUM_REQ-1, operand/result registers 0.
- States:
  - BOSTA: if any istek_gecerli_i is set, grant the first valid index strictly after the pointer, with wrap-around. Assert istek_hazir_o[grant] combinationally in this cycle only. Latch A, B, cikar, genis and id. Pointer <= grant. Next state ALT. No valid requests: stay in BOSTA.
  - ALT: drive top_islec0_o = A[31:0] and top_islec1_o = cikar ? ~B[31:0] : B[31:0]; top_carry_o = cikar. Register sum into result[31:0] and top_carry_i into carry register. Next state UST if genis, else YANIT.
  - UST: drive A[63:32] and (cikar ? ~B[63:32] : B[63:32]); top_carry_o = the carry captured in ALT. Register sum into result[63:32] and top_carry_i into carry register. Next state YANIT.
  - YANIT: sonuc_gecerli_o = 1; sonuc_o, sonuc_carry_o and sonuc_kimlik_o are held stable. On sonuc_gecerli_o & sonuc_hazir_i, go to BOSTA.
- For 32-bit ops, sonuc_o[63:32] = 0.
- In BOSTA and YANIT, the adder drive outputs are 0.
- Latency, counted from the accept cycle (cycle 0): result valid at cycle 2 for 32-bit ops, cycle 3 for 64-bit ops. The first new accept happens in the cycle after the result handshake.
- istek_hazir_o is never asserted outside BOSTA, and never for a non-valid requester.
- A requester dropping valid without a handshake is ignored. Operands are sampled only at grant.
- The adder is purely combinational; results are captured in the same cycle the operands are driven.
- Reset mid-operation drops the in-flight op. No result is emitted for it.

Optional Feature:
TOPLAYICI_HAKEM_TASMA_EN:
- Defined: adds output sonuc_tasma_o (1 bit), the signed overflow of the final word. It is computed as (opA_msb == opB'_msb) & (res_msb != opA_msb), using bit 31 for 32-bit ops and bit 63 for 64-bit ops, where B' is the inverted B when cikar = 1. It is registered with the result, valid with sonuc_gecerli_o, and reset to 0.
- Not defined: the port and its logic are absent.

Test Plan:
1. Req0 32-bit add, A=0xFFFFFFFF, B=1 -> sonuc_o=0, sonuc_carry_o=1, kimlik=0, sonuc_gecerli_o at cycle 2.
2. Req1 64-bit add, A=0x00000000_FFFFFFFF, B=1 -> top_carry_o=1 during UST; sonuc_o=0x00000001_00000000, carry=0, valid at cycle 3.
3. Req2 32-bit sub: 5-7 -> 0xFFFFFFFE, carry 0. Then 7-5 -> 2, carry 1. 64-bit 0-1 -> 0xFFFFFFFF_FFFFFFFF, carry 0.
4. All four requesters valid continuously, sonuc_hazir_i=1 -> grant order 0,1,2,3,0; istek_hazir_o is one-hot at each grant.
5. sonuc_hazir_i held low 5 cycles in YANIT -> outputs stable, no istek_hazir_o pulse; accept resumes the cycle after the handshake.
6. rstn_i pulsed low in UST -> all outputs 0 immediately, no result emitted; next grant goes to requester 0. With macro: 32-bit 0x7FFFFFFF+1 -> sonuc_tasma_o=1.
